// File: rtl/unified_mem_arbiter.sv
// Arbiter sharing one pipelined single-port RAM between instruction fetch (I) and load/store (D).
// Define ARB_PERF_CNT_EN to build the 32-bit stall counters; otherwise they read as zero.
module unified_mem_arbiter #(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned MEM_LAT    = 1,
    parameter int unsigned STARVE_MAX = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic              i_flush,
    output logic              i_gnt,
    output logic              i_rvalid,
    output logic [DATA_W-1:0] i_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [31:0]       i_stall_cnt,
    output logic [31:0]       d_stall_cnt
);
    localparam int unsigned StarveW =
        ($clog2(STARVE_MAX + 1) < 2) ? 2 : $clog2(STARVE_MAX + 1);
    localparam logic [StarveW-1:0] StarveSat = StarveW'(STARVE_MAX);

    logic [StarveW-1:0] starve_q, starve_d;
    // Tag pipe: valid bit plus owner bit (1 = D) per outstanding read slot.
    logic [MEM_LAT-1:0] tag_vld_q, tag_vld_d;
    logic [MEM_LAT-1:0] tag_isd_q, tag_isd_d;
    logic [DATA_W-1:0]  i_rdata_q, d_rdata_q;
    logic               starved;
    logic               last_vld;

    always_comb begin
        starved   = i_req && (starve_q == StarveSat);
        i_gnt     = 1'b0;
        d_gnt     = 1'b0;
        if (!reset) begin
            if (starved) begin
                i_gnt = 1'b1;
            end else if (d_req) begin
                d_gnt = 1'b1;
            end else if (i_req) begin
                i_gnt = 1'b1;
            end
        end
        mem_en    = i_gnt | d_gnt;
        mem_we    = d_gnt & d_we;
        mem_addr  = '0;
        mem_wdata = '0;
        if (d_gnt) begin
            mem_addr  = d_addr;
            mem_wdata = d_wdata;
        end else if (i_gnt) begin
            mem_addr  = i_addr;
        end
    end

    always_comb begin
        starve_d = starve_q;
        if (i_gnt) begin
            starve_d = '0;
        end else if (i_req && (starve_q != StarveSat)) begin
            starve_d = starve_q + 1'b1;
        end
    end

    // A flush kills I-owned reads already in flight; a fetch granted this cycle is kept.
    always_comb begin
        tag_vld_d    = '0;
        tag_isd_d    = '0;
        tag_vld_d[0] = i_gnt | (d_gnt & ~d_we);
        tag_isd_d[0] = d_gnt;
        for (int k = 1; k < int'(MEM_LAT); k++) begin
            tag_vld_d[k] = tag_vld_q[k-1] & ~(i_flush & ~tag_isd_q[k-1]);
            tag_isd_d[k] = tag_isd_q[k-1];
        end
    end

    always_comb begin
        last_vld = tag_vld_q[MEM_LAT-1] & ~reset;
        i_rvalid = last_vld & ~tag_isd_q[MEM_LAT-1] & ~i_flush;
        d_rvalid = last_vld & tag_isd_q[MEM_LAT-1];
        i_rdata  = reset ? '0 : (i_rvalid ? mem_rdata : i_rdata_q);
        d_rdata  = reset ? '0 : (d_rvalid ? mem_rdata : d_rdata_q);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            starve_q  <= '0;
            tag_vld_q <= '0;
            tag_isd_q <= '0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
        end else begin
            starve_q  <= starve_d;
            tag_vld_q <= tag_vld_d;
            tag_isd_q <= tag_isd_d;
            if (i_rvalid) begin
                i_rdata_q <= mem_rdata;
            end
            if (d_rvalid) begin
                d_rdata_q <= mem_rdata;
            end
        end
    end

`ifdef ARB_PERF_CNT_EN
    logic [31:0] i_stall_q, d_stall_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            i_stall_q <= '0;
            d_stall_q <= '0;
        end else begin
            if (i_req && !i_gnt) begin
                i_stall_q <= i_stall_q + 32'd1;
            end
            if (d_req && !d_gnt) begin
                d_stall_q <= d_stall_q + 32'd1;
            end
        end
    end

    assign i_stall_cnt = reset ? '0 : i_stall_q;
    assign d_stall_cnt = reset ? '0 : d_stall_q;
`else
    assign i_stall_cnt = '0;
    assign d_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Self-checking bench for unified_mem_arbiter: directed scenarios plus randomized traffic
// checked against a queue-based reference model of the arbiter and memory.
module tb_unified_mem_arbiter;
    localparam int LAT  = 3;
    localparam int SMAX = 3;
`ifdef ARB_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        i_req, i_flush, d_req, d_we;
    logic [31:0] i_addr, d_addr, d_wdata;
    logic        i_gnt, i_rvalid, d_gnt, d_rvalid, mem_en, mem_we;
    logic [31:0] i_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;
    logic [31:0] i_stall_cnt, d_stall_cnt;

    unified_mem_arbiter #(
        .ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT), .STARVE_MAX(SMAX)
    ) dut (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_flush(i_flush), .i_gnt(i_gnt),
        .i_rvalid(i_rvalid), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_gnt(d_gnt),
        .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .i_stall_cnt(i_stall_cnt), .d_stall_cnt(d_stall_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] init_word(input logic [7:0] idx);
        return {idx, 8'h5A, ~idx, idx ^ 8'h3C};
    endfunction

    // Environment: pipelined RAM with LAT-cycle read latency.
    logic [31:0] mem_arr [256];
    bit          written [256];
    logic [31:0] rd_pipe [LAT];
    always @(posedge clk) begin
        if (mem_en && mem_we) begin
            mem_arr[mem_addr[9:2]] <= mem_wdata;
            written[mem_addr[9:2]] <= 1'b1;
        end
        if (mem_en && !mem_we) begin
            rd_pipe[0] <= written[mem_addr[9:2]] ? mem_arr[mem_addr[9:2]]
                                                 : init_word(mem_addr[9:2]);
        end else begin
            rd_pipe[0] <= 32'hDEAD_BEEF;
        end
        for (int k = 1; k < LAT; k++) rd_pipe[k] <= rd_pipe[k-1];
    end
    assign mem_rdata = rd_pipe[LAT-1];

    // Reference model: shadow memory, starvation count, list of pending reads with due cycle.
    typedef struct {
        int          due;
        bit          own_d;
        logic [31:0] data;
    } rd_t;
    logic [31:0] ref_mem [256];
    rd_t         pend [$];
    int          cyc, starve, n_checks, n_pass;
    logic [31:0] last_i, last_d, m_istall, m_dstall;
    logic        e_i_gnt, e_d_gnt, e_i_rv, e_d_rv, e_mem_en, e_mem_we;
    logic [31:0] e_i_rd, e_d_rd, e_addr, e_wdata, e_istall, e_dstall;

    task automatic model_eval();
        e_i_gnt = 1'b0; e_d_gnt = 1'b0; e_i_rv = 1'b0; e_d_rv = 1'b0;
        e_i_rd  = last_i; e_d_rd = last_d;
        if (!reset) begin
            if (i_req && starve == SMAX) e_i_gnt = 1'b1;
            else if (d_req)              e_d_gnt = 1'b1;
            else if (i_req)              e_i_gnt = 1'b1;
            foreach (pend[k]) begin
                if (pend[k].due == cyc) begin
                    if (pend[k].own_d) begin
                        e_d_rv = 1'b1; e_d_rd = pend[k].data;
                    end else if (!i_flush) begin
                        e_i_rv = 1'b1; e_i_rd = pend[k].data;
                    end
                end
            end
        end else begin
            e_i_rd = '0; e_d_rd = '0;
        end
        e_mem_en = e_i_gnt | e_d_gnt;
        e_mem_we = e_d_gnt & d_we;
        e_addr   = e_d_gnt ? d_addr : (e_i_gnt ? i_addr : 32'd0);
        e_wdata  = e_d_gnt ? d_wdata : 32'd0;
        e_istall = (reset || !PERF) ? 32'd0 : m_istall;
        e_dstall = (reset || !PERF) ? 32'd0 : m_dstall;
    endtask

    task automatic model_commit();
        if (reset) begin
            pend.delete();
            starve = 0; last_i = '0; last_d = '0; m_istall = '0; m_dstall = '0;
        end else begin
            if (e_i_rv) last_i = e_i_rd;
            if (e_d_rv) last_d = e_d_rd;
            for (int k = pend.size() - 1; k >= 0; k--)
                if (pend[k].due == cyc || (i_flush && !pend[k].own_d)) pend.delete(k);
            if (e_i_gnt) pend.push_back('{due: cyc + LAT, own_d: 1'b0, data: ref_mem[i_addr[9:2]]});
            if (e_d_gnt && !d_we)
                pend.push_back('{due: cyc + LAT, own_d: 1'b1, data: ref_mem[d_addr[9:2]]});
            if (e_d_gnt && d_we) ref_mem[d_addr[9:2]] = d_wdata;
            if (e_i_gnt) starve = 0;
            else if (i_req && starve < SMAX) starve++;
            if (i_req && !e_i_gnt) m_istall++;
            if (d_req && !e_d_gnt) m_dstall++;
        end
        cyc++;
    endtask

    task automatic settle();
        #4;
        model_eval();
    endtask

    task automatic tick();
        @(posedge clk);
        model_commit();
        #1;
    endtask

    task automatic set_idle();
        i_req = 1'b0; i_addr = '0; i_flush = 1'b0;
        d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
    endtask

    task automatic idle(input int n);
        set_idle();
        for (int c = 0; c < n; c++) begin
            settle();
            tick();
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        for (int c = 0; c < 3; c++) begin
            i_req = 1'($urandom); d_req = 1'($urandom); d_we = 1'($urandom);
            i_flush = 1'($urandom); i_addr = $urandom; d_addr = $urandom; d_wdata = $urandom;
            settle();
            n_checks++;
            if ({i_gnt, d_gnt, i_rvalid, d_rvalid, mem_en, mem_we} !== 6'b0 || mem_addr !== '0 ||
                mem_wdata !== '0 || i_rdata !== '0 || d_rdata !== '0 || i_stall_cnt !== '0 ||
                d_stall_cnt !== '0)
                $display("FAIL reset_outputs c=%0d got gnt=%b%b rv=%b%b en=%b we=%b addr=%h wd=%h ird=%h drd=%h want all 0",
                         c, i_gnt, d_gnt, i_rvalid, d_rvalid, mem_en, mem_we, mem_addr, mem_wdata,
                         i_rdata, d_rdata);
            else n_pass++;
            tick();
        end
        reset = 1'b0;
        set_idle();
    endtask

    task automatic test_fetch_stream();
        int w;
        for (int c = 0; c < LAT + 4; c++) begin
            set_idle();
            if (c < 3) begin i_req = 1'b1; i_addr = 32'(c * 4); end
            settle();
            n_checks++;
            if (i_gnt !== (c < 3) || d_gnt !== 1'b0 || mem_addr !== i_addr || mem_we !== 1'b0)
                $display("FAIL fetch_gnt c=%0d got i=%b d=%b addr=%h want i=%b addr=%h",
                         c, i_gnt, d_gnt, mem_addr, c < 3, i_addr);
            else n_pass++;
            n_checks++;
            if (i_rvalid !== (c >= LAT && c < LAT + 3))
                $display("FAIL fetch_rvalid c=%0d got %b want %b", c, i_rvalid, c >= LAT && c < LAT + 3);
            else n_pass++;
            if (c >= LAT) begin
                w = (c - LAT > 2) ? 2 : c - LAT;
                n_checks++;
                if (i_rdata !== ref_mem[w])
                    $display("FAIL fetch_rdata c=%0d got %h want %h", c, i_rdata, ref_mem[w]);
                else n_pass++;
            end
            tick();
        end
    endtask

    task automatic test_load_vs_fetch();
        for (int c = 0; c <= LAT + 1; c++) begin
            set_idle();
            if (c == 0) begin d_req = 1'b1; d_addr = 32'h100; end
            if (c <= 1) begin i_req = 1'b1; i_addr = 32'h10; end
            settle();
            if (c <= 1) begin
                n_checks++;
                if (d_gnt !== (c == 0) || i_gnt !== (c == 1) ||
                    mem_addr !== (c == 0 ? 32'h100 : 32'h10))
                    $display("FAIL lvf_gnt c=%0d got d=%b i=%b addr=%h", c, d_gnt, i_gnt, mem_addr);
                else n_pass++;
            end
            n_checks++;
            if (d_rvalid !== (c == LAT) || i_rvalid !== (c == LAT + 1))
                $display("FAIL lvf_rvalid c=%0d got d=%b i=%b want d=%b i=%b",
                         c, d_rvalid, i_rvalid, c == LAT, c == LAT + 1);
            else n_pass++;
            if (c == LAT) begin
                n_checks++;
                if (d_rdata !== ref_mem[8'h40])
                    $display("FAIL lvf_drdata got %h want %h", d_rdata, ref_mem[8'h40]);
                else n_pass++;
            end
            if (c == LAT + 1) begin
                n_checks++;
                if (i_rdata !== ref_mem[8'h04])
                    $display("FAIL lvf_irdata got %h want %h", i_rdata, ref_mem[8'h04]);
                else n_pass++;
            end
            tick();
        end
    endtask

    task automatic test_starvation();
        int          st;
        logic [31:0] wd [SMAX + 2];
        st = 0;
        for (int k = 0; k < SMAX + 2; k++) wd[k] = $urandom;
        for (int c = 0; c < SMAX + 2 + LAT; c++) begin
            set_idle();
            if (c < SMAX + 2) begin
                d_req = 1'b1; d_we = 1'b1; d_addr = 32'h300 + 32'(st * 4); d_wdata = wd[st];
                i_req = 1'b1; i_addr = (c <= SMAX) ? 32'h40 : 32'h44;
            end
            settle();
            if (c < SMAX + 2) begin
                n_checks++;
                if (i_gnt !== (c == SMAX) || d_gnt !== (c != SMAX))
                    $display("FAIL starve_gnt c=%0d got i=%b d=%b want i=%b d=%b",
                             c, i_gnt, d_gnt, c == SMAX, c != SMAX);
                else n_pass++;
                n_checks++;
                if (mem_we !== (c != SMAX) || mem_wdata !== (c != SMAX ? wd[st] : 32'd0))
                    $display("FAIL starve_bus c=%0d got we=%b wd=%h", c, mem_we, mem_wdata);
                else n_pass++;
                if (c != SMAX) st++;
            end
            n_checks++;
            if (d_rvalid !== 1'b0) $display("FAIL store_rvalid c=%0d got %b want 0", c, d_rvalid);
            else n_pass++;
            tick();
        end
    endtask

    task automatic test_flush();
        logic exp_irv;
        for (int c = 0; c <= LAT + 3; c++) begin
            set_idle();
            case (c)
                0: begin i_req = 1'b1; i_addr = 32'h20; end
                1: begin d_req = 1'b1; d_addr = 32'h104; end
                2: begin i_req = 1'b1; i_addr = 32'h24; end
                3: begin i_req = 1'b1; i_addr = 32'h80; i_flush = 1'b1; end
                default: ;
            endcase
            settle();
            if (c == 3) begin
                n_checks++;
                if (i_gnt !== 1'b1 || mem_addr !== 32'h80)
                    $display("FAIL flush_gnt got i=%b addr=%h want 1 80", i_gnt, mem_addr);
                else n_pass++;
            end
            exp_irv = (c == LAT && LAT < 3) || (c == LAT + 3);
            n_checks++;
            if (i_rvalid !== exp_irv || d_rvalid !== (c == LAT + 1))
                $display("FAIL flush_rvalid c=%0d got i=%b d=%b want i=%b d=%b",
                         c, i_rvalid, d_rvalid, exp_irv, c == LAT + 1);
            else n_pass++;
            if (c == LAT + 1) begin
                n_checks++;
                if (d_rdata !== ref_mem[8'h41])
                    $display("FAIL flush_drdata got %h want %h", d_rdata, ref_mem[8'h41]);
                else n_pass++;
            end
            if (c == LAT + 3) begin
                n_checks++;
                if (i_rdata !== ref_mem[8'h20])
                    $display("FAIL flush_irdata got %h want %h", i_rdata, ref_mem[8'h20]);
                else n_pass++;
            end
            tick();
        end
        // Flush landing exactly on a returning fetch word suppresses it.
        for (int c = 0; c <= LAT + 1; c++) begin
            set_idle();
            if (c == 0) begin i_req = 1'b1; i_addr = 32'h30; end
            if (c == LAT) i_flush = 1'b1;
            settle();
            n_checks++;
            if (i_rvalid !== 1'b0 || i_rdata !== ref_mem[8'h20])
                $display("FAIL flush_last c=%0d got rv=%b rd=%h want 0 %h",
                         c, i_rvalid, i_rdata, ref_mem[8'h20]);
            else n_pass++;
            tick();
        end
    endtask

    task automatic test_reset_midop();
        for (int c = 0; c <= LAT + 3; c++) begin
            set_idle();
            reset = (c == 1 || c == 2);
            if (c == 0) begin d_req = 1'b1; d_addr = 32'h200; end
            settle();
            if (c == 0) begin
                n_checks++;
                if (d_gnt !== 1'b1) $display("FAIL rstmid_gnt got %b want 1", d_gnt);
                else n_pass++;
            end else if (reset) begin
                n_checks++;
                if ({d_gnt, i_gnt, d_rvalid, i_rvalid, mem_en} !== 5'b0 || d_rdata !== '0 ||
                    i_rdata !== '0 || i_stall_cnt !== '0 || d_stall_cnt !== '0)
                    $display("FAIL rstmid_outputs c=%0d got rv=%b drd=%h ird=%h want 0",
                             c, d_rvalid, d_rdata, i_rdata);
                else n_pass++;
            end else begin
                n_checks++;
                if (d_rvalid !== 1'b0 || i_rvalid !== 1'b0 || d_rdata !== '0)
                    $display("FAIL rstmid_stale c=%0d got d_rv=%b i_rv=%b drd=%h want 0 0 0",
                             c, d_rvalid, i_rvalid, d_rdata);
                else n_pass++;
            end
            tick();
        end
        reset = 1'b0;
    endtask

    task automatic test_perf();
        for (int c = 0; c <= SMAX + 2; c++) begin
            set_idle();
            if (c <= SMAX + 1) begin d_req = 1'b1; d_addr = 32'h180 + 32'(c * 4); end
            if (c == SMAX + 1) d_addr = 32'h180 + 32'(SMAX * 4);
            if (c <= SMAX) begin i_req = 1'b1; i_addr = 32'h60; end
            settle();
            n_checks++;
            if (i_stall_cnt !== (PERF ? 32'((c > SMAX) ? SMAX : c) : 32'd0) ||
                d_stall_cnt !== (PERF ? 32'((c > SMAX) ? 1 : 0) : 32'd0))
                $display("FAIL perf_cnt c=%0d got i=%0d d=%0d", c, i_stall_cnt, d_stall_cnt);
            else n_pass++;
            tick();
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            if (!(i_req && !e_i_gnt)) begin
                i_req  = ($urandom_range(0, 3) != 0);
                i_addr = {22'd0, 8'($urandom), 2'b00};
            end
            if (!(d_req && !e_d_gnt)) begin
                d_req   = ($urandom_range(0, 1) == 0);
                d_we    = 1'($urandom);
                d_addr  = {22'd0, 8'($urandom), 2'b00};
                d_wdata = $urandom;
            end
            i_flush = ($urandom_range(0, 9) == 0);
            settle();
            n_checks++;
            if (i_gnt !== e_i_gnt || d_gnt !== e_d_gnt)
                $display("FAIL rand_gnt c=%0d got i=%b d=%b want i=%b d=%b",
                         c, i_gnt, d_gnt, e_i_gnt, e_d_gnt);
            else n_pass++;
            n_checks++;
            if (mem_en !== e_mem_en || mem_we !== e_mem_we || mem_addr !== e_addr ||
                mem_wdata !== e_wdata)
                $display("FAIL rand_bus c=%0d got en=%b we=%b a=%h wd=%h want %b %b %h %h",
                         c, mem_en, mem_we, mem_addr, mem_wdata, e_mem_en, e_mem_we, e_addr, e_wdata);
            else n_pass++;
            n_checks++;
            if (i_rvalid !== e_i_rv || i_rdata !== e_i_rd)
                $display("FAIL rand_iresp c=%0d got %b %h want %b %h",
                         c, i_rvalid, i_rdata, e_i_rv, e_i_rd);
            else n_pass++;
            n_checks++;
            if (d_rvalid !== e_d_rv || d_rdata !== e_d_rd)
                $display("FAIL rand_dresp c=%0d got %b %h want %b %h",
                         c, d_rvalid, d_rdata, e_d_rv, e_d_rd);
            else n_pass++;
            n_checks++;
            if (i_stall_cnt !== e_istall || d_stall_cnt !== e_dstall)
                $display("FAIL rand_perf c=%0d got %0d %0d want %0d %0d",
                         c, i_stall_cnt, d_stall_cnt, e_istall, e_dstall);
            else n_pass++;
            tick();
        end
        set_idle();
    endtask

    initial begin
        n_checks = 0; n_pass = 0; cyc = 0; starve = 0;
        last_i = '0; last_d = '0; m_istall = '0; m_dstall = '0;
        e_i_gnt = 1'b0; e_d_gnt = 1'b0;
        for (int k = 0; k < 256; k++) ref_mem[k] = init_word(k[7:0]);
        reset = 1'b1;
        set_idle();
        @(posedge clk);
        #1;
        test_reset();
        test_fetch_stream();
        idle(LAT + 1);
        test_load_vs_fetch();
        idle(LAT + 1);
        test_starvation();
        idle(LAT + 1);
        test_flush();
        idle(LAT + 1);
        test_reset_midop();
        idle(LAT + 1);
        test_perf();
        idle(LAT + 1);
        test_random();
        idle(LAT + 1);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
